spi_miso_return_path: RTL and testbench

- Master-side receive engine for the 16-slave SPI fabric: it runs one SPI mode-0 read transaction against one addressed slave.
- Drives `cs_addr` and `cs_en` into the 1-to-16 slave-select decoder and generates SCLK.
- Selects the addressed slave's MISO line and shifts in DATA_W bits, MSB first.
- Presents the received word on a valid/ready output handshake with overrun detection.

---
 rtl/spi_miso_return_path.sv | 119 +++++++++++
 tb/tb_spi_miso_return_path.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_miso_return_path.sv
// Master-side SPI mode-0 receive engine: selects one of 16 MISO lines through the
// bit-reversed slave index, clocks in DATA_W bits MSB first, and hands the word out on valid/ready.
module spi_miso_return_path #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        addr,
  input  logic [15:0]       miso,
  output logic              sclk,
  output logic              cs_en,
  output logic [3:0]        cs_addr,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun
);

  // Output handshake: a word transfers on every cycle where rx_valid && rx_ready;
  // rx_data is held stable while rx_valid is high and not yet accepted.
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BITS     = 6'(DATA_W);

  state_t             state;
  logic [7:0]         div_cnt;
  logic [5:0]         bit_cnt;
  logic [DATA_W-1:0]  shreg;
  logic [3:0]         sel;
  logic               div_done;
  logic [DATA_W-1:0]  shift_in;

  // The decoder treats cs_addr[0] as the index MSB, so the line select is bit-reversed.
  assign sel      = {cs_addr[0], cs_addr[1], cs_addr[2], cs_addr[3]};
  assign div_done = (div_cnt == DIV_LAST);
  assign shift_in = {shreg[DATA_W-2:0], miso[sel]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sclk     <= 1'b0;
      cs_en    <= 1'b0;
      cs_addr  <= '0;
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          div_cnt <= '0;
          if (start) begin
            cs_addr <= addr;
            cs_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_done) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 6'd1;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_done) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            state   <= LOW;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LOW: begin
          if (div_done) begin
            div_cnt <= '0;
            if (bit_cnt < BITS) begin
              sclk    <= 1'b1;
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 6'd1;
              state   <= HIGH;
            end else begin
              cs_en <= 1'b0;
              state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          // A same-cycle consume makes room for the new word, so only an unaccepted word overruns.
          rx_data  <= shreg;
          rx_valid <= 1'b1;
          overrun  <= rx_valid && !rx_ready;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_miso_return_path.sv
// Directed bench for spi_miso_return_path: behavioural slave on one MISO line,
// expected words queued at start and compared when the engine completes.
module tb_spi_miso_return_path;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  addr;
  logic [15:0] miso;
  logic        sclk;
  logic        cs_en;
  logic [3:0]  cs_addr;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        overrun;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  logic [3:0]  slave_line = 4'd0;
  logic [7:0]  slave_word = 8'h00;
  logic [15:0] miso_bg    = 16'h0000;
  int          bit_idx    = 7;
  int          sclk_rises = 0;

  spi_miso_return_path #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .miso(miso),
    .sclk(sclk), .cs_en(cs_en), .cs_addr(cs_addr), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave presents the next bit after each falling SCLK edge.
  always @(negedge sclk) bit_idx = bit_idx - 1;
  always @(posedge sclk) sclk_rises = sclk_rises + 1;

  always @* begin
    miso = miso_bg;
    if (bit_idx >= 0 && bit_idx < 8) miso[slave_line] = slave_word[bit_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One read; ready_at/pulse_at give the cycle (counted from acceptance) for a one-cycle
  // rx_ready or stray start pulse, -1 for none.
  task automatic do_read(input logic [3:0] a, input logic [3:0] line, input logic [7:0] w,
                         input logic [15:0] bg, input int ready_at, input int pulse_at,
                         output logic ovr, output logic cs_ok);
    int n;
    logic [7:0] e;
    slave_line = line;
    slave_word = w;
    miso_bg    = bg;
    bit_idx    = 7;
    sclk_rises = 0;
    exp_q.push_back(w);
    addr  = a;
    start = 1'b1;
    n     = 0;
    cs_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n <= 68 && !cs_en) cs_ok = 1'b0;
      start    = (n == pulse_at);
      rx_ready = (n == ready_at);
      if (n == 30) addr = a ^ 4'hF;
    end while (busy && n < 200);
    ovr = overrun;
    check("latency", n, 70);
    check("sclk_rises", sclk_rises, 8);
    check("rx_valid_done", rx_valid, 1'b1);
    e = exp_q.pop_front();
    check("rx_data", rx_data, e);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_valid_consumed", rx_valid, 1'b0);
  endtask

  initial begin
    logic ovr, cs_ok;
    int   bad, n;
    rst_n    = 1'b0;
    start    = 1'b1;
    addr     = 4'h0;
    rx_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_en", cs_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_txn", busy, 1'b0);

    do_read(4'b0000, 4'd0, 8'hA5, 16'h0000, -1, -1, ovr, cs_ok);
    check("basic_cs_en", cs_ok, 1'b1);
    check("basic_overrun", ovr, 1'b0);
    consume();

    do_read(4'b0001, 4'd8, 8'h3C, 16'hFFFF, -1, -1, ovr, cs_ok);
    consume();
    do_read(4'b0100, 4'd2, 8'hC3, 16'hFFFF, -1, -1, ovr, cs_ok);
    consume();

    do_read(4'b0101, 4'd10, 8'h11, 16'($urandom_range(0, 16'hFFFF)), -1, 20, ovr, cs_ok);
    check("first_overrun", ovr, 1'b0);
    bad = 0;
    sclk_rises = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bad++;
    end
    check("stray_start_idle", bad, 0);
    check("stray_start_sclk", sclk_rises, 0);

    do_read(4'b1001, 4'd9, 8'h22, 16'($urandom_range(0, 16'hFFFF)), -1, -1, ovr, cs_ok);
    check("overrun_pulse", ovr, 1'b1);
    @(negedge clk);
    check("overrun_single", overrun, 1'b0);
    check("overrun_valid", rx_valid, 1'b1);
    check("overrun_data", rx_data, 8'h22);
    consume();

    do_read(4'b0011, 4'd12, 8'h5A, 16'h0000, -1, -1, ovr, cs_ok);
    check("pending_overrun", ovr, 1'b0);
    do_read(4'b1100, 4'd3, 8'h96, 16'hFFFF, 69, -1, ovr, cs_ok);
    check("cpl_overrun", ovr, 1'b0);
    @(negedge clk);
    check("cpl_valid", rx_valid, 1'b1);
    check("cpl_data", rx_data, 8'h96);
    consume();

    // Abandon a transfer during the 4th HIGH phase (cycles 29..32 after acceptance).
    slave_line = 4'd0;
    slave_word = 8'hFF;
    miso_bg    = 16'h0000;
    bit_idx    = 7;
    addr       = 4'b0000;
    start      = 1'b1;
    n          = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (n < 30);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_cs_en", cs_en, 1'b0);
    check("midrst_sclk", sclk, 1'b0);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (rx_valid !== 1'b0) bad++;
    end
    check("midrst_no_valid", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
